// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP raster-scan sequencer.
package lbp_pkg;

  localparam int IMG_W_DEF  = 128;
  localparam int IMG_H_DEF  = 128;
  localparam int ADDR_W_DEF = 14;

  // Window slots in raster order: 0 1 2 / 3 4 5 / 6 7 8
  localparam logic [3:0] SLOT_CENTRE   = 4'd4;
  localparam logic [3:0] SLOT_COL2_TOP = 4'd2;
  localparam logic [3:0] SLOT_COL2_MID = 4'd5;
  localparam logic [3:0] SLOT_COL2_BOT = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SLIDE,
    LAST,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/lbp_addr_gen.sv
// Centre-pixel row/column counters and 3x3 tap address generation.
// tap_addr is formed from the centre as it will be after a pending advance,
// so the first read of a new window can be issued on the transfer edge.
module lbp_addr_gen import lbp_pkg::*; #(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [3:0]        slot,
  output logic [ADDR_W-1:0] centre,
  output logic              row_last,
  output logic              img_last,
  output logic [ADDR_W-1:0] tap_addr
);

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] R_LAST   = ADDR_W'(IMG_H - 2);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] centre_nxt;

  assign row_last = (col == C_LAST);
  assign img_last = row_last && (row == R_LAST);

  // Centre after this cycle's advance: +1 along a row, +3 to wrap to column 1 of the next row
  always_comb begin
    centre_nxt = centre;
    if (advance) begin
      centre_nxt = row_last ? centre + ROW_STEP : centre + ONE;
    end
  end

  // Offset mux: slot index selects one of the nine neighbours of the centre
  always_comb begin
    tap_addr = centre_nxt;
    case (slot)
      4'd0:        tap_addr = centre_nxt - W_A - ONE;
      4'd1:        tap_addr = centre_nxt - W_A;
      4'd2:        tap_addr = centre_nxt - W_A + ONE;
      4'd3:        tap_addr = centre_nxt - ONE;
      SLOT_CENTRE: tap_addr = centre_nxt;
      4'd5:        tap_addr = centre_nxt + ONE;
      4'd6:        tap_addr = centre_nxt + W_A - ONE;
      4'd7:        tap_addr = centre_nxt + W_A;
      4'd8:        tap_addr = centre_nxt + W_A + ONE;
      default:     tap_addr = centre_nxt;
    endcase
  end

  // Row/column counters and centre address, stepped on each window transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row    <= ONE;
      col    <= ONE;
      centre <= W_A + ONE;
    end else if (advance) begin
      if (row_last) begin
        row <= row + ONE;
        col <= ONE;
      end else begin
        col <= col + ONE;
      end
      centre <= centre_nxt;
    end
  end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster-scan sequencer: fetches 3x3 windows from gray memory (full fill at
// row start, one new column per step), steers returned data into window
// slots and hands each window to the kernel with a valid/ready handshake.
module lbp_scan_ctrl import lbp_pkg::*; #(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              win_we,
  output logic [3:0]        win_sel,
  output logic              win_shift,
  output logic              kern_valid,
  input  logic              kern_ready,
  output logic [ADDR_W-1:0] kern_addr,
  output logic              finish
);

  state_t            state, state_n;
  logic [3:0]        k, k_n;
  logic [3:0]        slot_n, req_slot;
  logic              advance;
  logic              req_n, shift_n, valid_n, finish_n;
  logic [ADDR_W-1:0] centre, tap_addr;
  logic              row_last, img_last;

  lbp_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .slot    (slot_n),
    .centre  (centre),
    .row_last(row_last),
    .img_last(img_last),
    .tap_addr(tap_addr)
  );

  // Next-state and read-counter logic; a transfer in EMIT advances the centre
  always_comb begin
    state_n = state;
    k_n     = k;
    advance = 1'b0;
    case (state)
      IDLE:  if (gray_ready) begin
               state_n = FILL;
               k_n     = '0;
             end
      FILL:  if (k == 4'd8) state_n = LAST;
             else           k_n     = k + 4'd1;
      SLIDE: if (k == 4'd2) state_n = LAST;
             else           k_n     = k + 4'd1;
      LAST:  state_n = EMIT;
      EMIT:  if (kern_ready) begin
               advance = 1'b1;
               k_n     = '0;
               if (img_last)      state_n = DONE;
               else if (row_last) state_n = FILL;
               else               state_n = SLIDE;
             end
      DONE:  state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from the next state so that every port comes straight from a flop
  always_comb begin
    req_n    = 1'b0;
    slot_n   = '0;
    shift_n  = 1'b0;
    valid_n  = 1'b0;
    finish_n = 1'b0;
    case (state_n)
      FILL: begin
        req_n  = 1'b1;
        slot_n = k_n;
      end
      SLIDE: begin
        req_n   = 1'b1;
        shift_n = (state != SLIDE);
        case (k_n)
          4'd0:    slot_n = SLOT_COL2_TOP;
          4'd1:    slot_n = SLOT_COL2_MID;
          default: slot_n = SLOT_COL2_BOT;
        endcase
      end
      EMIT:    valid_n  = 1'b1;
      DONE:    finish_n = 1'b1;
      default: ;
    endcase
  end

  // State, output registers and the one-stage request-to-write slot pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      k          <= '0;
      gray_req   <= 1'b0;
      req_slot   <= '0;
      gray_addr  <= '0;
      win_we     <= 1'b0;
      win_sel    <= '0;
      win_shift  <= 1'b0;
      kern_valid <= 1'b0;
      kern_addr  <= '0;
      finish     <= 1'b0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      gray_req   <= req_n;
      req_slot   <= slot_n;
      if (req_n) gray_addr <= tap_addr;
      win_we     <= gray_req;
      win_sel    <= req_slot;
      win_shift  <= shift_n;
      kern_valid <= valid_n;
      if (state_n == EMIT) kern_addr <= centre;
      finish     <= finish_n;
    end
  end

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl: a 5x5 instance for directed timing,
// stall and mid-scan reset runs, and an 11x7 instance for a randomized scan.
`timescale 1ns/1ps
module tb_lbp_scan_ctrl;

  localparam int W_A = 5,  H_A = 5, AW_A = 5;
  localparam int W_B = 11, H_B = 7, AW_B = 7;

  typedef struct { int addr; int slot; bit shift; } req_t;
  typedef struct { int addr; int gap; } kern_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // DUT A signals
  logic            rst_a, gr_a, req_a, we_a, shift_a, kv_a, kr_a, fin_a;
  logic [AW_A-1:0] addr_a, kaddr_a;
  logic [3:0]      sel_a;
  // DUT B signals
  logic            rst_b, gr_b, req_b, we_b, shift_b, kv_b, kr_b, fin_b;
  logic [AW_B-1:0] addr_b, kaddr_b;
  logic [3:0]      sel_b;

  lbp_scan_ctrl #(.IMG_W(W_A), .IMG_H(H_A), .ADDR_W(AW_A)) dut_a (
    .clk(clk), .reset(rst_a), .gray_ready(gr_a), .gray_req(req_a), .gray_addr(addr_a),
    .win_we(we_a), .win_sel(sel_a), .win_shift(shift_a), .kern_valid(kv_a),
    .kern_ready(kr_a), .kern_addr(kaddr_a), .finish(fin_a));

  lbp_scan_ctrl #(.IMG_W(W_B), .IMG_H(H_B), .ADDR_W(AW_B)) dut_b (
    .clk(clk), .reset(rst_b), .gray_ready(gr_b), .gray_req(req_b), .gray_addr(addr_b),
    .win_we(we_b), .win_sel(sel_b), .win_shift(shift_b), .kern_valid(kv_b),
    .kern_ready(kr_b), .kern_addr(kaddr_b), .finish(fin_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  req_t  qa_req[$], qb_req[$];
  kern_t qa_kern[$], qb_kern[$];

  int mode_a = 0, mode_b = 0;     // kern_ready: 0 high, 1 low, 2 random
  bit rnd_gr_a = 0, rnd_gr_b = 0; // toggle gray_ready randomly once a scan runs
  bit a_gap_chk = 0;
  int a_last = -1;
  int req_cnt_a = 0, xfer_a = 0, req_cnt_b = 0, xfer_b = 0, last_kaddr_b = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every interior centre in raster order; fill at row start, one column otherwise
  task automatic build_expect(input int w, input int h, input bit to_b);
    req_t  rq;
    kern_t kq;
    int    n = 0;
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        if (c == 1) begin
          for (int s = 0; s < 9; s++) begin
            rq.addr = (r + s / 3 - 1) * w + c + (s % 3) - 1;
            rq.slot = s;
            rq.shift = 1'b0;
            if (to_b) qb_req.push_back(rq); else qa_req.push_back(rq);
          end
        end else begin
          for (int i = 0; i < 3; i++) begin
            rq.addr = (r + i - 1) * w + c + 1;
            rq.slot = 3 * i + 2;
            rq.shift = (i == 0);
            if (to_b) qb_req.push_back(rq); else qa_req.push_back(rq);
          end
        end
        kq.addr = r * w + c;
        kq.gap  = (n == 0) ? 10 : ((c == 1) ? 11 : 5);
        if (to_b) qb_kern.push_back(kq); else qa_kern.push_back(kq);
        n++;
      end
    end
  endtask

  // Input drivers, applied 1ns after each rising edge
  initial begin
    kr_a = 1'b1; kr_b = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode_a)
        0: kr_a = 1'b1;
        1: kr_a = 1'b0;
        default: kr_a = ($urandom_range(0, 2) != 0);
      endcase
      case (mode_b)
        0: kr_b = 1'b1;
        1: kr_b = 1'b0;
        default: kr_b = ($urandom_range(0, 1) != 0);
      endcase
      if (rnd_gr_a) gr_a = 1'($urandom_range(0, 1));
      if (rnd_gr_b) gr_b = 1'($urandom_range(0, 1));
    end
  end

  // Monitor A
  bit   pa_v = 0, ha_v = 0;
  int   pa_slot = 0, ha_addr = 0;
  req_t ra;
  kern_t ka;
  always @(negedge clk) begin
    if (!rst_a) begin
      pa_v = 0; ha_v = 0;
    end else begin
      bit exp_shift;
      exp_shift = 0;
      chk("a_win_we", int'(we_a), int'(pa_v));
      if (pa_v) chk("a_win_sel", int'(sel_a), pa_slot);
      pa_v = 0;
      if (req_a) begin
        req_cnt_a++;
        chk("a_req_expected", int'(qa_req.size() > 0), 1);
        if (qa_req.size() > 0) begin
          ra = qa_req.pop_front();
          chk("a_gray_addr", int'(addr_a), ra.addr);
          exp_shift = ra.shift;
          pa_v = 1; pa_slot = ra.slot;
          if (a_last < 0) a_last = cyc;
        end
      end
      chk("a_win_shift", int'(shift_a), int'(exp_shift));
      if (kv_a) chk("a_no_req_in_emit", int'(req_a), 0);
      if (ha_v) begin
        chk("a_valid_hold", int'(kv_a), 1);
        chk("a_addr_hold", int'(kaddr_a), ha_addr);
      end
      if (kv_a && kr_a) begin
        chk("a_kern_expected", int'(qa_kern.size() > 0), 1);
        if (qa_kern.size() > 0) begin
          ka = qa_kern.pop_front();
          chk("a_kern_addr", int'(kaddr_a), ka.addr);
          if (a_gap_chk) chk("a_window_spacing", cyc - a_last, ka.gap);
        end
        a_last = cyc;
        xfer_a++;
      end
      ha_v = kv_a && !kr_a;
      ha_addr = int'(kaddr_a);
      if (fin_a) chk("a_finish_early", qa_kern.size(), 0);
    end
  end

  // Monitor B
  bit   pb_v = 0, hb_v = 0;
  int   pb_slot = 0, hb_addr = 0;
  req_t rb;
  kern_t kb;
  always @(negedge clk) begin
    if (!rst_b) begin
      pb_v = 0; hb_v = 0;
    end else begin
      bit exp_shift;
      exp_shift = 0;
      chk("b_win_we", int'(we_b), int'(pb_v));
      if (pb_v) chk("b_win_sel", int'(sel_b), pb_slot);
      pb_v = 0;
      if (req_b) begin
        req_cnt_b++;
        chk("b_req_expected", int'(qb_req.size() > 0), 1);
        if (qb_req.size() > 0) begin
          rb = qb_req.pop_front();
          chk("b_gray_addr", int'(addr_b), rb.addr);
          exp_shift = rb.shift;
          pb_v = 1; pb_slot = rb.slot;
        end
      end
      chk("b_win_shift", int'(shift_b), int'(exp_shift));
      if (kv_b) chk("b_no_req_in_emit", int'(req_b), 0);
      if (hb_v) begin
        chk("b_valid_hold", int'(kv_b), 1);
        chk("b_addr_hold", int'(kaddr_b), hb_addr);
      end
      if (kv_b && kr_b) begin
        chk("b_kern_expected", int'(qb_kern.size() > 0), 1);
        if (qb_kern.size() > 0) begin
          kb = qb_kern.pop_front();
          chk("b_kern_addr", int'(kaddr_b), kb.addr);
        end
        last_kaddr_b = int'(kaddr_b);
        xfer_b++;
      end
      hb_v = kv_b && !kr_b;
      hb_addr = int'(kaddr_b);
      if (fin_b) chk("b_finish_early", qb_kern.size(), 0);
    end
  end

  task automatic chk_zero_a(input string tag);
    chk({tag, "_gray_req"},   int'(req_a),   0);
    chk({tag, "_gray_addr"},  int'(addr_a),  0);
    chk({tag, "_win_we"},     int'(we_a),    0);
    chk({tag, "_win_sel"},    int'(sel_a),   0);
    chk({tag, "_win_shift"},  int'(shift_a), 0);
    chk({tag, "_kern_valid"}, int'(kv_a),    0);
    chk({tag, "_kern_addr"},  int'(kaddr_a), 0);
    chk({tag, "_finish"},     int'(fin_a),   0);
  endtask

  task automatic start_a();
    @(posedge clk); #2 gr_a = 1'b1;
    @(posedge clk); #2 gr_a = 1'b0;
    rnd_gr_a = 1;
  endtask

  task automatic reset_a();
    rnd_gr_a = 0; gr_a = 1'b0;
    rst_a = 1'b0;
    qa_req.delete(); qa_kern.delete();
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b1;
    req_cnt_a = 0; xfer_a = 0; a_last = -1;
  endtask

  task automatic wait_fin_a(input int maxc);
    int i = 0;
    while (!fin_a && i < maxc) begin @(posedge clk); #2; i++; end
    chk("a_finish_reached", int'(fin_a), 1);
  endtask

  task automatic wait_fin_b(input int maxc);
    int i = 0;
    while (!fin_b && i < maxc) begin @(posedge clk); #2; i++; end
    chk("b_finish_reached", int'(fin_b), 1);
  endtask

  initial begin
    int i;
    rst_a = 1'b0; rst_b = 1'b0; gr_a = 1'b0; gr_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero_a("a_rst");
    chk("b_rst_outputs", int'(req_b | we_b | shift_b | kv_b | fin_b | (|addr_b) | (|kaddr_b) | (|sel_b)), 0);

    // Run 1: idle wait, then full 5x5 scan with kern_ready held high and timing checks
    rst_a = 1'b1;
    repeat (4) @(posedge clk);
    #2 chk("a_idle_no_req", int'(req_a), 0);
    build_expect(W_A, H_A, 0);
    a_gap_chk = 1; mode_a = 0;
    start_a();
    wait_fin_a(300);
    chk("a_run1_req_left", qa_req.size(), 0);
    chk("a_run1_kern_left", qa_kern.size(), 0);
    chk("a_run1_transfers", xfer_a, (W_A - 2) * (H_A - 2));
    chk("a_run1_requests", req_cnt_a, (H_A - 2) * (9 + 3 * (W_A - 3)));
    repeat (6) begin
      @(posedge clk); #2;
      chk("a_finish_held", int'(fin_a), 1);
      chk("a_done_no_valid", int'(kv_a), 0);
      chk("a_done_no_req", int'(req_a), 0);
    end

    // Run 2: hold kern_ready low in the first EMIT for 7 cycles, then random
    reset_a();
    build_expect(W_A, H_A, 0);
    a_gap_chk = 0; mode_a = 1;
    start_a();
    i = 0;
    while (!kv_a && i < 40) begin @(posedge clk); #2; i++; end
    chk("a_first_valid_seen", int'(kv_a), 1);
    repeat (7) @(posedge clk);
    #2;
    chk("a_stall_valid", int'(kv_a), 1);
    chk("a_stall_addr", int'(kaddr_a), W_A + 1);
    mode_a = 2;
    wait_fin_a(400);
    chk("a_run2_kern_left", qa_kern.size(), 0);
    chk("a_run2_transfers", xfer_a, (W_A - 2) * (H_A - 2));

    // Run 3: reset during SLIDE, then a clean restart
    reset_a();
    build_expect(W_A, H_A, 0);
    a_gap_chk = 1; mode_a = 0;
    start_a();
    i = 0;
    while (!shift_a && i < 40) begin @(posedge clk); #2; i++; end
    chk("a_shift_seen", int'(shift_a), 1);
    #1 rst_a = 1'b0;
    #1 chk_zero_a("a_midreset");
    reset_a();
    build_expect(W_A, H_A, 0);
    start_a();
    wait_fin_a(300);
    chk("a_run3_kern_left", qa_kern.size(), 0);
    chk("a_run3_transfers", xfer_a, (W_A - 2) * (H_A - 2));

    // Run 4: non-square image with random kern_ready and random gray_ready
    @(posedge clk); #2 rst_b = 1'b1;
    build_expect(W_B, H_B, 1);
    mode_b = 2;
    @(posedge clk); #2 gr_b = 1'b1;
    @(posedge clk); #2 gr_b = 1'b0;
    rnd_gr_b = 1;
    wait_fin_b(1500);
    chk("b_req_left", qb_req.size(), 0);
    chk("b_kern_left", qb_kern.size(), 0);
    chk("b_requests", req_cnt_b, (H_B - 2) * (9 + 3 * (W_B - 3)));
    chk("b_transfers", xfer_b, (W_B - 2) * (H_B - 2));
    chk("b_last_kern_addr", last_kaddr_b, (H_B - 2) * W_B + W_B - 2);
    repeat (4) @(posedge clk);
    #2 chk("b_finish_held", int'(fin_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
